// File: rtl/mode_select_fsm.sv
// rtl/mode_select_fsm.sv - game mode selector with select-key debounce and release waits
module mode_select_fsm #(
    parameter int NUM_GAMES = 2,
    parameter int MODE_W    = 2,
    parameter int DEBOUNCE  = 4
) (
    input  logic                 clk,
    input  logic                 iReset,
    input  logic [NUM_GAMES-1:0] iSel,
    input  logic                 iBack,
    input  logic                 iGameDone,
    output logic [MODE_W-1:0]    oMode,
    output logic                 oStart,
    output logic                 oExit,
    output logic                 oMenu
);

    localparam int KW = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1;
    localparam int CW = $clog2(DEBOUNCE);

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_SEL_DEB   = 3'd1,
        S_SEL_WAIT  = 3'd2,
        S_ACTIVE    = 3'd3,
        S_EXIT_WAIT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     count_q, count_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              start_q, start_d;
    logic              exit_q, exit_d;
    logic              menu_q, menu_d;
    logic [KW-1:0]     low_idx;

    // Lowest-indexed pressed key wins when several are down together.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_GAMES - 1; i >= 0; i--) begin
            if (iSel[i]) begin
                low_idx = KW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        count_d = count_q;
        case (state_q)
            S_MENU: begin
                if (iSel != '0) begin
                    k_d     = low_idx;
                    count_d = CW'(1);
                    state_d = S_SEL_DEB;
                end
            end
            S_SEL_DEB: begin
                if (!iSel[k_q]) begin
                    state_d = S_MENU;
                end else if (count_q == CW'(DEBOUNCE - 1)) begin
                    state_d = S_SEL_WAIT;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_SEL_WAIT: begin
                if (iSel == '0) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (iBack || iGameDone) begin
                    state_d = S_EXIT_WAIT;
                end
            end
            S_EXIT_WAIT: begin
                if (!iBack && (iSel == '0)) begin
                    state_d = S_MENU;
                end
            end
            default: begin
                state_d = S_MENU;
                k_d     = '0;
                count_d = '0;
            end
        endcase

        // Outputs are registered from the state being entered at this edge.
        mode_d  = (state_d == S_ACTIVE) ? (MODE_W'(k_d) + MODE_W'(1)) : '0;
        start_d = (state_q == S_SEL_WAIT) && (state_d == S_ACTIVE);
        exit_d  = (state_q == S_EXIT_WAIT) && (state_d == S_MENU);
        menu_d  = (state_d == S_MENU);
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q <= S_MENU;
            k_q     <= '0;
            count_q <= '0;
            mode_q  <= '0;
            start_q <= 1'b0;
            exit_q  <= 1'b0;
            menu_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            exit_q  <= exit_d;
            menu_q  <= menu_d;
        end
    end

    assign oMode  = mode_q;
    assign oStart = start_q;
    assign oExit  = exit_q;
    assign oMenu  = menu_q;

endmodule

// File: tb/tb_mode_select_fsm.sv
// tb/tb_mode_select_fsm.sv - directed self-checking bench for mode_select_fsm
module tb_mode_select_fsm;

    logic       clk = 1'b0;
    logic       iReset;
    logic [2:0] iSel;
    logic       iBack;
    logic       iGameDone;
    logic [1:0] oMode;
    logic       oStart;
    logic       oExit;
    logic       oMenu;

    int checks   = 0;
    int failures = 0;

    mode_select_fsm #(
        .NUM_GAMES(3),
        .MODE_W   (2),
        .DEBOUNCE (4)
    ) dut (
        .clk      (clk),
        .iReset   (iReset),
        .iSel     (iSel),
        .iBack    (iBack),
        .iGameDone(iGameDone),
        .oMode    (oMode),
        .oStart   (oStart),
        .oExit    (oExit),
        .oMenu    (oMenu)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] m, input logic s,
                           input logic e, input logic mn);
        chk({tag, ".mode"},  {6'd0, oMode},  {6'd0, m});
        chk({tag, ".start"}, {7'd0, oStart}, {7'd0, s});
        chk({tag, ".exit"},  {7'd0, oExit},  {7'd0, e});
        chk({tag, ".menu"},  {7'd0, oMenu},  {7'd0, mn});
    endtask

    initial begin
        iReset = 1'b1; iSel = 3'b000; iBack = 1'b0; iGameDone = 1'b0;
        tick(); tick();
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b1);
        iReset = 1'b0;
        tick();
        chk_all("idle", 2'd0, 1'b0, 1'b0, 1'b1);

        // 1: select game 1, held 4 edges then released
        iSel = 3'b010;
        tick(); chk_all("t1.e1", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t1.e2", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t1.e3", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t1.e4", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t1.hold", 2'd0, 1'b0, 1'b0, 1'b0);
        iSel = 3'b000;
        tick(); chk_all("t1.act", 2'd2, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("t1.act2", 2'd2, 1'b0, 1'b0, 1'b0);
        iGameDone = 1'b1;
        tick(); chk_all("t1.done", 2'd0, 1'b0, 1'b0, 1'b0);
        iGameDone = 1'b0;
        tick(); chk_all("t1.exit", 2'd0, 1'b0, 1'b1, 1'b1);
        tick(); chk_all("t1.menu", 2'd0, 1'b0, 1'b0, 1'b1);

        // 2: glitch shorter than the debounce window
        iSel = 3'b001;
        tick(); chk_all("t2.e1", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t2.e2", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t2.e3", 2'd0, 1'b0, 1'b0, 1'b0);
        iSel = 3'b000;
        tick(); chk_all("t2.rej", 2'd0, 1'b0, 1'b0, 1'b1);
        tick(); chk_all("t2.menu", 2'd0, 1'b0, 1'b0, 1'b1);

        // 3: two keys at once; lowest wins; late key holds off ACTIVE
        iSel = 3'b110;
        repeat (4) tick();
        chk_all("t3.wait", 2'd0, 1'b0, 1'b0, 1'b0);
        iSel = 3'b100;
        tick(); chk_all("t3.hold1", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t3.hold2", 2'd0, 1'b0, 1'b0, 1'b0);
        iSel = 3'b000;
        tick(); chk_all("t3.act", 2'd2, 1'b1, 1'b0, 1'b0);
        iBack = 1'b1;
        tick(); chk_all("t3.back", 2'd0, 1'b0, 1'b0, 1'b0);
        iBack = 1'b0;
        tick(); chk_all("t3.exit", 2'd0, 1'b0, 1'b1, 1'b1);

        // 4: back key held 5 cycles from game 2
        iSel = 3'b100;
        repeat (4) tick();
        iSel = 3'b000;
        tick(); chk_all("t4.act", 2'd3, 1'b1, 1'b0, 1'b0);
        iBack = 1'b1;
        tick(); chk_all("t4.b1", 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_all("t4.bheld", 2'd0, 1'b0, 1'b0, 1'b0);
        end
        iBack = 1'b0;
        tick(); chk_all("t4.exit", 2'd0, 1'b0, 1'b1, 1'b1);
        tick(); chk_all("t4.menu", 2'd0, 1'b0, 1'b0, 1'b1);

        // 5: game done and back together
        iSel = 3'b001;
        repeat (4) tick();
        iSel = 3'b000;
        tick(); chk_all("t5.act", 2'd1, 1'b1, 1'b0, 1'b0);
        iGameDone = 1'b1; iBack = 1'b1;
        tick(); chk_all("t5.both", 2'd0, 1'b0, 1'b0, 1'b0);
        iGameDone = 1'b0;
        tick(); chk_all("t5.w1", 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("t5.w2", 2'd0, 1'b0, 1'b0, 1'b0);
        iBack = 1'b0;
        tick(); chk_all("t5.exit", 2'd0, 1'b0, 1'b1, 1'b1);
        tick(); chk_all("t5.menu", 2'd0, 1'b0, 1'b0, 1'b1);

        // 6: reset in the middle of a game, then a fresh selection
        iSel = 3'b001;
        repeat (4) tick();
        iSel = 3'b000;
        tick(); chk_all("t6.act", 2'd1, 1'b1, 1'b0, 1'b0);
        iReset = 1'b1;
        tick(); chk_all("t6.rst", 2'd0, 1'b0, 1'b0, 1'b1);
        iReset = 1'b0;
        tick(); chk_all("t6.idle", 2'd0, 1'b0, 1'b0, 1'b1);
        iSel = 3'b010;
        repeat (4) tick();
        iSel = 3'b000;
        tick(); chk_all("t6.act2", 2'd2, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("t6.act3", 2'd2, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
